// File: rtl/banked_data_array_if.sv
// Request/response bundle for banked_data_array: read and write request fields, read response, init status.
// Latency: none (wires only); no backpressure: requests arriving before init_done are dropped by the array.
interface banked_data_array_if #(
    parameter int NUM_WAYS   = 2,
    parameter int NUM_SETS   = 8,
    parameter int LINE_BYTES = 32
);
    localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int LINE_W = 8 * LINE_BYTES;

    logic                  init_done;
    logic                  rd_en;
    logic [WAY_W-1:0]      rway;
    logic [IDX_W-1:0]      rindex;
    logic [LINE_BYTES-1:0] write_en;
    logic [WAY_W-1:0]      wway;
    logic [IDX_W-1:0]      windex;
    logic [LINE_W-1:0]     datain;
    logic                  rvalid;
    logic [LINE_W-1:0]     dataout;
    logic                  parity_err;

    modport master (
        output rd_en, rway, rindex, write_en, wway, windex, datain,
        input  init_done, rvalid, dataout, parity_err
    );

    modport slave (
        input  rd_en, rway, rindex, write_en, wway, windex, datain,
        output init_done, rvalid, dataout, parity_err
    );
endinterface

// File: rtl/banked_data_array.sv
// Multi-way cache data array, byte write enables, clear-after-reset sequencer, optional byte parity (DATA_ARRAY_PARITY_EN).
// Latency: read data and rvalid 1 cycle after rd_en, fully pipelined; init_done after NUM_SETS clear cycles.
// Backpressure: none; requests issued before init_done are ignored, reads never stall behind writes.
module banked_data_array #(
    parameter int NUM_WAYS   = 2,
    parameter int NUM_SETS   = 8,
    parameter int LINE_BYTES = 32
) (
    input  logic                clk,
    input  logic                rst,
    banked_data_array_if.slave  bus
);
    localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int LINE_W = 8 * LINE_BYTES;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic                init_done_q, init_done_d;
    logic                rvalid_q, rvalid_d;
    logic [LINE_W-1:0]   dataout_q, dataout_d;

    logic [LINE_W-1:0]     mem_q [NUM_WAYS][NUM_SETS];
    logic [LINE_BYTES-1:0] byte_we [NUM_WAYS];
    logic [IDX_W-1:0]      wr_set;
    logic [LINE_W-1:0]     wr_dat;
    logic                  wr_way_ok, rd_way_ok, rd_fire, fwd_hit;
    logic [LINE_W-1:0]     rd_line;

    always_comb begin
        wr_way_ok = int'(bus.wway) < NUM_WAYS;
        rd_way_ok = int'(bus.rway) < NUM_WAYS;
        rd_fire   = (state_q == ST_READY) && bus.rd_en;
        fwd_hit   = rd_fire && wr_way_ok && (|bus.write_en)
                    && (bus.rway == bus.wway) && (bus.rindex == bus.windex);

        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == ST_CLEAR) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == IDX_W'(NUM_SETS - 1))
                state_d = ST_READY;
        end
        init_done_d = (state_d == ST_READY);

        // Clear owns the write port; it zeroes one set in every way per cycle
        wr_set = (state_q == ST_CLEAR) ? ptr_q : bus.windex;
        wr_dat = (state_q == ST_CLEAR) ? '0 : bus.datain;
        for (int w = 0; w < NUM_WAYS; w++) begin
            byte_we[w] = '0;
            if (state_q == ST_CLEAR)
                byte_we[w] = '1;
            else if (wr_way_ok && (bus.wway == WAY_W'(w)))
                byte_we[w] = bus.write_en;
        end

        rd_line = '0;
        if (rd_way_ok) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (fwd_hit && bus.write_en[b])
                    rd_line[b*8 +: 8] = bus.datain[b*8 +: 8];
                else
                    rd_line[b*8 +: 8] = mem_q[bus.rway][bus.rindex][b*8 +: 8];
            end
        end

        rvalid_d  = rd_fire;
        dataout_d = rd_fire ? rd_line : dataout_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            ptr_q       <= '0;
            init_done_q <= 1'b0;
            rvalid_q    <= 1'b0;
            dataout_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            init_done_q <= init_done_d;
            rvalid_q    <= rvalid_d;
            dataout_q   <= dataout_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WAYS; w++)
            for (int b = 0; b < LINE_BYTES; b++)
                if (byte_we[w][b])
                    mem_q[w][wr_set][b*8 +: 8] <= wr_dat[b*8 +: 8];
    end

`ifdef DATA_ARRAY_PARITY_EN
    logic [LINE_BYTES-1:0] par_q [NUM_WAYS][NUM_SETS];
    logic [LINE_BYTES-1:0] wr_par;
    logic                  rd_par_bad;
    logic                  parity_err_q, parity_err_d;

    always_comb begin
        for (int b = 0; b < LINE_BYTES; b++)
            wr_par[b] = ^wr_dat[b*8 +: 8];
        // Forwarded bytes bypass storage, so only stored bytes can mismatch
        rd_par_bad = 1'b0;
        if (rd_way_ok) begin
            for (int b = 0; b < LINE_BYTES; b++)
                if (!(fwd_hit && bus.write_en[b]))
                    rd_par_bad = rd_par_bad
                        | (par_q[bus.rway][bus.rindex][b] ^ (^mem_q[bus.rway][bus.rindex][b*8 +: 8]));
        end
        parity_err_d = rd_fire && rd_par_bad;
    end

    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WAYS; w++)
            for (int b = 0; b < LINE_BYTES; b++)
                if (byte_we[w][b])
                    par_q[w][wr_set][b] <= wr_par[b];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            parity_err_q <= 1'b0;
        else
            parity_err_q <= parity_err_d;
    end

    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.init_done = init_done_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.dataout   = dataout_q;
endmodule

// File: tb/tb_banked_data_array.sv
// Random and directed stimulus for banked_data_array against a byte-level reference array of line contents.
module tb_banked_data_array;
    localparam int NW    = 2;
    localparam int NS    = 8;
    localparam int LB    = 32;
    localparam int LW    = 8 * LB;
    localparam int WAY_W = 1;
    localparam int IDX_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    banked_data_array_if #(.NUM_WAYS(NW), .NUM_SETS(NS), .LINE_BYTES(LB)) bus();

    banked_data_array #(.NUM_WAYS(NW), .NUM_SETS(NS), .LINE_BYTES(LB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [LW-1:0] mdl [NW][NS];
    logic [LW-1:0] exp_dat;
    bit            mdl_ready;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.rd_en    = 1'b0;
        bus.rway     = '0;
        bus.rindex   = '0;
        bus.write_en = '0;
        bus.wway     = '0;
        bus.windex   = '0;
        bus.datain   = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_init_done"}, bus.init_done, 0);
        chk({tag, "_rvalid"}, bus.rvalid, 0);
        chk({tag, "_dataout"}, bus.dataout, 0);
        chk({tag, "_parity_err"}, bus.parity_err, 0);
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int i = 0; i < LW / 32; i++)
            l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Entered with rst high, just after an edge; leaves the array ready with the model cleared.
    task automatic init_seq();
        for (int w = 0; w < NW; w++)
            for (int s = 0; s < NS; s++)
                mdl[w][s] = '0;
        mdl_ready = 0;
        exp_dat   = '0;
        rst = 1'b0;
        chk("clear_c1_init_done", bus.init_done, 0);
        for (int k = 1; k <= NS; k++) begin
            // Requests during clear must be ignored
            bus.rd_en    = 1'b1;
            bus.rway     = WAY_W'($urandom_range(0, NW - 1));
            bus.rindex   = IDX_W'($urandom_range(0, NS - 1));
            bus.write_en = '1;
            bus.wway     = WAY_W'($urandom_range(0, NW - 1));
            bus.windex   = IDX_W'($urandom_range(0, NS - 1));
            bus.datain   = '1;
            @(posedge clk); #1;
            chk("clear_init_done", bus.init_done, (k == NS) ? 1 : 0);
            chk("clear_rvalid", bus.rvalid, 0);
            chk("clear_dataout", bus.dataout, 0);
        end
        idle_inputs();
        mdl_ready = 1;
    endtask

    task automatic apply(input bit re, input int rw, input int ri,
                         input logic [LB-1:0] we, input int ww, input int wi,
                         input logic [LW-1:0] d);
        bit exp_v;
        bus.rd_en    = re;
        bus.rway     = WAY_W'(rw);
        bus.rindex   = IDX_W'(ri);
        bus.write_en = we;
        bus.wway     = WAY_W'(ww);
        bus.windex   = IDX_W'(wi);
        bus.datain   = d;
        // Write lands first: a same-cycle read of the same line sees the new bytes
        if (mdl_ready && ww < NW)
            for (int b = 0; b < LB; b++)
                if (we[b])
                    mdl[ww][wi][b*8 +: 8] = d[b*8 +: 8];
        exp_v = mdl_ready && re;
        if (exp_v)
            exp_dat = (rw < NW) ? mdl[rw][ri] : '0;
        @(posedge clk); #1;
        chk("init_done", bus.init_done, 1);
        chk("rvalid", bus.rvalid, exp_v);
        chk("dataout", bus.dataout, exp_dat);
        chk("parity_err", bus.parity_err, 0);
    endtask

    task automatic read_all_lines();
        for (int w = 0; w < NW; w++)
            for (int s = 0; s < NS; s++)
                apply(1, w, s, '0, 0, 0, '0);
        apply(0, 0, 0, '0, 0, 0, '0);
    endtask

    task automatic random_traffic(input int n);
        logic [LB-1:0] we;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                0:       we = '0;
                1:       we = '1;
                default: we = $urandom;
            endcase
            apply(bit'($urandom_range(0, 1)), $urandom_range(0, NW - 1), $urandom_range(0, 3),
                  we, $urandom_range(0, NW - 1), $urandom_range(0, 3), rand_line());
        end
    endtask

    initial begin
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        init_seq();
        read_all_lines();

        apply(0, 0, 0, 32'h0000_000F, 1, 3, {LB{8'hAA}});
        apply(1, 1, 3, '0, 0, 0, '0);
        apply(0, 0, 0, '0, 0, 0, '0);

        apply(1, 0, 5, 32'hFFFF_FFFF, 0, 5, {LB{8'h5A}});
        apply(1, 1, 5, '0, 0, 0, '0);

        for (int s = 0; s < 4; s++)
            apply(1, 1, s, '0, 0, 0, '0);
        apply(0, 0, 0, '0, 0, 0, '0);

        random_traffic(400);

`ifdef DATA_ARRAY_PARITY_EN
        apply(0, 0, 0, '1, 0, 2, rand_line());
        dut.par_q[0][2][7] = ~dut.par_q[0][2][7];
        bus.rd_en = 1'b1; bus.rway = '0; bus.rindex = IDX_W'(2);
        @(posedge clk); #1;
        chk("par_bad_rvalid", bus.rvalid, 1);
        chk("par_bad_err", bus.parity_err, 1);
        dut.par_q[0][2][7] = ~dut.par_q[0][2][7];
        @(posedge clk); #1;
        chk("par_clean_err", bus.parity_err, 0);
        idle_inputs();
        exp_dat = mdl[0][2];
        apply(0, 0, 0, '0, 0, 0, '0);
`endif

        // Reset lands while a read response is on the outputs
        bus.rd_en  = 1'b1;
        bus.rway   = WAY_W'(1);
        bus.rindex = IDX_W'(3);
        @(posedge clk); #1;
        chk("pre_rst_rvalid", bus.rvalid, 1);
        rst = 1'b1;
        idle_inputs();
        #1;
        chk_reset_outputs("rst_mid_read");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_clear_init_done", bus.init_done, 0);
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_mid_clear");
        @(posedge clk); #1;
        init_seq();
        read_all_lines();
        random_traffic(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
